// File: rtl/ysyx_22041405_mdu.sv
`default_nettype none
// =============================================================================
// Module   : ysyx_22041405_mdu
// Brief    : Iterative RV M-extension multiply/divide unit, one bit per cycle.
// Revision : 1.0
// =============================================================================
module ysyx_22041405_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_op;
  logic                 r_sign1;
  logic                 r_sign2;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_result;
  logic                 r_out_valid;

  logic                 w_accept;
  logic                 w_s1_signed;
  logic                 w_s2_signed;
  logic                 w_s1_neg;
  logic                 w_s2_neg;
  logic [WIDTH-1:0]     w_abs1;
  logic [WIDTH-1:0]     w_abs2;
  logic                 w_div_zero;
  logic                 w_div_ovf;
  logic                 w_fast;
  logic [WIDTH-1:0]     w_fast_res;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_dshift;
  logic                 w_dge;
  logic [WIDTH-1:0]     w_dsub;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_mul_res;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_div_res;
  logic [WIDTH-1:0]     w_fix_res;

  // Operand decode: src1 signed for MUL/MULH/MULHSU/DIV/REM, src2 for MULH/DIV/REM
  assign w_s1_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign w_s2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  assign w_s1_neg    = w_s1_signed && src1[WIDTH-1];
  assign w_s2_neg    = w_s2_signed && src2[WIDTH-1];
  assign w_abs1      = w_s1_neg ? (~src1 + 1'b1) : src1;
  assign w_abs2      = w_s2_neg ? (~src2 + 1'b1) : src2;

  assign w_accept    = in_valid && (r_state == S_IDLE) && !flush;
  assign w_div_zero  = op[2] && (src2 == '0);
  assign w_div_ovf   = op[2] && !op[0] && (src1 == c_MIN) && (src2 == c_ONES);
  assign w_fast      = w_div_zero || w_div_ovf;
  assign w_fast_res  = w_div_zero ? (op[1] ? src1 : c_ONES)
                                  : (op[1] ? '0 : src1);

  // Shift-add multiply: the sum keeps its carry so the right shift loses nothing
  assign w_addend    = r_acc[0] ? r_opnd : '0;
  assign w_msum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mul_step  = {w_msum, r_acc[WIDTH-1:1]};

  // Restoring divide: the shifted partial remainder needs one extra bit
  assign w_dshift    = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_dge       = w_dshift >= {1'b0, r_opnd};
  assign w_dsub      = WIDTH'(w_dshift - {1'b0, r_opnd});
  assign w_div_step  = w_dge ? {w_dsub, r_acc[WIDTH-2:0], 1'b1}
                             : {w_dshift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod      = (r_sign1 ^ r_sign2) ? (~r_acc + 1'b1) : r_acc;
  assign w_mul_res   = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
  assign w_quot      = r_acc[WIDTH-1:0];
  assign w_rem       = r_acc[2*WIDTH-1:WIDTH];
  assign w_div_res   = r_op[1] ? (r_sign1 ? (~w_rem + 1'b1) : w_rem)
                               : ((r_sign1 ^ r_sign2) ? (~w_quot + 1'b1) : w_quot);
  assign w_fix_res   = r_op[2] ? w_div_res : w_mul_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = (r_state == S_IDLE) && !flush;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : S_BUSY;
      S_BUSY: if (r_cnt == c_LAST) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_sign1 <= w_s1_neg;
            r_sign2 <= w_s2_neg;
            r_cnt   <= '0;
            r_opnd  <= op[2] ? w_abs2 : w_abs1;
            r_acc   <= {{WIDTH{1'b0}}, (op[2] ? w_abs1 : w_abs2)};
            if (w_fast) r_result <= w_fast_res;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= r_op[2] ? w_div_step : w_mul_step;
        end
        S_FIX: begin
          if (!flush) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041405_mdu.sv
`default_nettype none
// =============================================================================
// Module   : tb_ysyx_22041405_mdu
// Brief    : Self-checking bench for ysyx_22041405_mdu against an arithmetic model.
// Revision : 1.0
// =============================================================================
module tb_ysyx_22041405_mdu;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [2:0]  op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          lat;
  } txn_t;
  txn_t pend[$];
  logic exp_ov;
  logic exp_rdy;

  ysyx_22041405_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .op(op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // RISC-V M-extension semantics from 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q;
    logic [63:0]        ua, ub, p;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    q   = '0;
    model = '0;
    case (f)
      3'd0: begin p = ua * ub; model = p[31:0]; end
      3'd1: begin p = sa * sb; model = p[63:32]; end
      3'd2: begin p = sa * ub; model = p[63:32]; end
      3'd3: begin p = ua * ub; model = p[63:32]; end
      3'd4: begin
        if (b == 0) model = 32'hFFFF_FFFF;
        else if (ovf) model = a;
        else begin q = sa / sb; model = q[31:0]; end
      end
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) model = a;
        else if (ovf) model = 32'h0;
        else begin q = sa % sb; model = q[31:0]; end
      end
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (f == 3'd4 || f == 3'd6) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    return (f[2] && (b == 0 || ovf)) ? 1 : LAT;
  endfunction

  // Cycle-by-cycle comparison against the queued model transactions
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      exp_ov = (pend.size() > 0) && (cyc >= pend[0].acc + pend[0].lat);
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      if (exp_ov) check("result", result, pend[0].exp);
      exp_rdy = (pend.size() == 0) && !flush;
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      if (flush) pend.delete();
      else if (exp_ov && out_ready) void'(pend.pop_front());
      else if (in_valid && exp_rdy)
        pend.push_back('{model(op, src1, src2), cyc, lat_of(op, src1, src2)});
    end
  end

  task automatic run_vec(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold);
    int n;
    int acc;
    check({name, " model"}, model(f, a, b), exp);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    op        = f;
    src1      = a;
    src2      = b;
    out_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin timeout({name, " accept"}); return; end
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    if (!out_valid) begin timeout({name, " out_valid"}); return; end
    check({name, " latency"}, 32'(cyc - acc), 32'(lat_of(f, a, b)));
    check({name, " result"}, result, exp);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({name, " held result"}, result, exp);
      check({name, " held in_ready"}, {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n_ov;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0;
    @(posedge clk); #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    run_vec("MUL 7*-3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_vec("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    run_vec("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_vec("MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0);
    run_vec("MULHSU min*max",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_vec("MULH -1*5",       3'd1, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 0);
    run_vec("MUL shift",       3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, 0);
    run_vec("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    run_vec("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    run_vec("DIVU 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        0);
    run_vec("REMU 100/7",      3'd7, 32'd100,       32'd7,         32'd2,         0);
    run_vec("DIV 7/-3",        3'd4, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFE, 0);
    run_vec("REM 7/-3",        3'd6, 32'd7,         32'hFFFF_FFFD, 32'd1,         0);
    run_vec("REM -8/-3",       3'd6, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0);
    run_vec("DIVU max/1",      3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 0);
    run_vec("REMU max/16",     3'd7, 32'hFFFF_FFFF, 32'h10,        32'hF,         0);
    run_vec("DIV 5/0",         3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_vec("REMU 5/0",        3'd7, 32'd5,         32'd0,         32'd5,         0);
    run_vec("DIV min/-1",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_vec("REM min/-1",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

    run_vec("DIVU backpressure", 3'd5, 32'd100, 32'd7, 32'd14, 10);
    run_vec("REMU after bp",     3'd7, 32'd100, 32'd7, 32'd2,  0);

    // Flush in the fifth BUSY cycle
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd5; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    check("flush op accepted", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("in_ready after flush", {31'b0, in_ready}, 32'd1);
    n_ov = 0;
    repeat (40) begin @(negedge clk); if (out_valid) n_ov++; end
    check("flushed op out_valid count", 32'(n_ov), 32'd0);

    // Flush coincident with a request blocks the accept
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd4;
    @(negedge clk);
    check("in_ready under flush", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_ov = 0;
    repeat (40) begin @(negedge clk); if (out_valid) n_ov++; end
    check("blocked accept out_valid count", 32'(n_ov), 32'd0);

    // Asynchronous reset in the middle of BUSY
    run_vec("MUL pre-reset", 3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'd1; src1 = 32'd9; src2 = 32'd9;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("result before reset", result, 32'h2345_6780);
    #1 rst = 1'b1;
    #1;
    check("async reset out_valid", {31'b0, out_valid}, 32'd0);
    check("async reset result", result, 32'd0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", {31'b0, in_ready}, 32'd1);
    n_ov = 0;
    repeat (40) begin @(negedge clk); if (out_valid) n_ov++; end
    check("post-reset out_valid count", 32'(n_ov), 32'd0);

    run_vec("DIVU after reset", 3'd5, 32'd100, 32'd7, 32'd14, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
